vmem_write_arbiter: RTL and testbench
=====================================

Name: vmem_write_arbiter

Overview:
- Owns the single write port of the 640x480x24 video frame memory and shares it between two requesters.
- Requester 1: the CPU-side pixel store path, using a req/ack handshake.
- Requester 2: a built-in rectangle-fill engine that clears or paints a rectangle at up to one pixel per clock.
- Outputs connect directly to the frame memory's write address, write-enable and write-data inputs. At most one pixel write is issued per cycle.

Parameters:
- H_W, 10, horizontal address width
- V_W, 9, vertical address width
- H_MAX, 640, number of columns; valid h is 0..H_MAX-1
- V_MAX, 480, number of rows; valid v is 0..V_MAX-1
- DATA_W, 24, pixel width (RGB888)

Ports:
- clk  in  1  clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- cpu_req_i  in  1  CPU write request; held with address/data stable until ack
- cpu_h_i  in  H_W  CPU pixel column
- cpu_v_i  in  V_W  CPU pixel row
- cpu_data_i  in  DATA_W  CPU pixel value
- cpu_ack_o  out  1  one-cycle pulse; CPU write issued this cycle
- fill_start_i  in  1  start fill (sampled only in IDLE)
- fill_h0_i / fill_v0_i  in  H_W / V_W  top-left corner, inclusive
- fill_h1_i / fill_v1_i  in  H_W / V_W  bottom-right corner, inclusive
- fill_color_i  in  DATA_W  fill value
- fill_busy_o  out  1  fill engine in RUN
- fill_done_o  out  1  one-cycle pulse after the last fill pixel is written
- fill_err_o  out  1  one-cycle pulse; start rejected
- waddr_h_o  out  H_W  frame memory write column
- waddr_v_o  out  V_W  frame memory write row
- we_o  out  1  frame memory write enable
- vga_wdata_o  out  DATA_W  frame memory write data

Behaviour:
- Reset:
  - All outputs are registered and reset to 0.
  - FSM goes to IDLE; round-robin pointer goes to CPU.
  - Reset asserted mid-fill abandons the fill immediately: no done pulse, and no write in the reset cycle.
- Requests:
  - CPU request is eligible when cpu_req_i=1 and cpu_ack_o=0 in the current cycle. This prevents double-issue of a held request, so CPU throughput is at most one write per 2 cycles.
  - Fill request is eligible when the FSM is in RUN.
- Arbitration, evaluated each cycle:
  - Only one eligible: it is granted.
  - Both eligible: the pointer holder is granted, and the pointer moves to the other requester.
  - No contention: the pointer is unchanged.
- Grant timing:
  - A grant decided in cycle N produces we_o=1 with the granted address and data in cycle N+1 (1-cycle latency).
  - A CPU grant also asserts cpu_ack_o=1 in cycle N+1.
  - we_o=0 in any cycle following a no-grant cycle; address and data then hold their last values.
- Fill FSM: IDLE -> RUN -> DONE -> IDLE.
  - IDLE, fill_start_i=1: validate h0<=h1<H_MAX and v0<=v1<V_MAX.
    - Fail: fill_err_o=1 for the next cycle; FSM stays in IDLE.
    - Pass: latch corners and color; cursor=(h0,v0); go to RUN; fill_busy_o=1 from the next cycle.
  - RUN: on each fill grant, write the cursor pixel and advance the cursor in raster order.
    - h<h1: h+1.
    - h==h1: h=h0, v+1.
    - Granted pixel is (h1,v1): go to DONE.
  - DONE, one cycle: fill_done_o=1, fill_busy_o=0; return to IDLE. This is the same cycle in which the last pixel's we_o is high.
- Inputs to the fill engine:
  - fill_start_i is ignored in RUN and DONE.
  - Corner and color inputs are don't-care after the start is accepted.
- Degenerate fill: a 1x1 rectangle (h0=h1, v0=v1) performs exactly one write.
- Transfer counts:
  - An uncontended fill takes exactly (h1-h0+1)*(v1-v0+1) consecutive we_o cycles.
  - Under continuous CPU traffic, each requester receives at least every other write slot.
- Address widths: cursor arithmetic is done in H_W/V_W bits; validation guarantees no overflow.

Optional Feature:
- Macro: VMEM_FILL_ABORT_EN.
- Defined:
  - Adds input fill_abort_i (1 bit).
  - When fill_abort_i=1 in RUN, the fill makes no further grants and the FSM goes directly to IDLE. fill_busy_o=0 next cycle; fill_done_o is not pulsed.
  - A write already issued in the current cycle completes.
  - fill_abort_i is ignored outside RUN.
- Undefined: the port is absent and a fill always runs to completion.

Test Plan:
- Reset then idle -> all outputs 0; we_o stays 0 for 10 cycles.
- CPU req h=5,v=7,data=24'hFF0000, held until ack -> exactly one cycle with we_o=1, addr (5,7), data FF0000, cpu_ack_o=1 in the same cycle; no second write while req is held through the ack.
- Fill (2,3)-(4,4), color 24'h00FF00, no CPU traffic -> 6 consecutive writes: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4); fill_done_o pulses with the last; fill_busy_o is high for exactly 6 cycles.
- Fill (0,0)-(9,0) with the CPU requesting continuously (req re-raised immediately after each ack) -> fill and CPU writes interleave; all 10 fill pixels are written; every CPU request is acked within 2 cycles of its first eligible cycle.
- Start with h1=640, or h0=6,h1=5 -> fill_err_o pulse, fill_busy_o stays 0, no writes.
- Reset asserted after 3 pixels of a 4x4 fill -> outputs 0 immediately; after reset release, no further writes and no fill_done_o. With VMEM_FILL_ABORT_EN, fill_abort_i after 3 pixels -> at most 4 writes total, fill_busy_o drops, no fill_done_o.

Source files
------------

// File: rtl/vmem_write_arbiter.sv
`timescale 1ns/1ps
// vmem_write_arbiter: round-robin share of the frame-memory write port between a CPU
// req/ack store path and a rectangle-fill engine. Define VMEM_FILL_ABORT_EN to add fill_abort_i.
module vmem_write_arbiter #(
  parameter int H_W    = 10,
  parameter int V_W    = 9,
  parameter int H_MAX  = 640,
  parameter int V_MAX  = 480,
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req_i,
  input  logic [H_W-1:0]    cpu_h_i,
  input  logic [V_W-1:0]    cpu_v_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  output logic              cpu_ack_o,
  input  logic              fill_start_i,
  input  logic [H_W-1:0]    fill_h0_i,
  input  logic [V_W-1:0]    fill_v0_i,
  input  logic [H_W-1:0]    fill_h1_i,
  input  logic [V_W-1:0]    fill_v1_i,
  input  logic [DATA_W-1:0] fill_color_i,
`ifdef VMEM_FILL_ABORT_EN
  input  logic              fill_abort_i,
`endif
  output logic              fill_busy_o,
  output logic              fill_done_o,
  output logic              fill_err_o,
  output logic [H_W-1:0]    waddr_h_o,
  output logic [V_W-1:0]    waddr_v_o,
  output logic              we_o,
  output logic [DATA_W-1:0] vga_wdata_o
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  typedef struct packed {
    logic [H_W-1:0]    h;
    logic [V_W-1:0]    v;
    logic [DATA_W-1:0] d;
  } wr_t;

  localparam logic [H_W:0] H_LIM = (H_W+1)'(H_MAX);
  localparam logic [V_W:0] V_LIM = (V_W+1)'(V_MAX);

  state_e            state_q, state_d;
  logic              rr_q, rr_d;  // 0: CPU wins the next contended cycle
  logic [H_W-1:0]    h0_q, h1_q, ch_q, ch_d;
  logic [V_W-1:0]    v1_q, cv_q, cv_d;
  logic [DATA_W-1:0] color_q;
  wr_t               wr_q, wr_d;
  logic              we_q, ack_q, err_q;
  logic              abort, accept, start_ok, last_px;
  logic              cpu_elig, fill_elig, gnt_cpu, gnt_fill;

`ifdef VMEM_FILL_ABORT_EN
  assign abort = fill_abort_i;
`else
  assign abort = 1'b0;
`endif

  assign start_ok = (fill_h0_i <= fill_h1_i) && ({1'b0, fill_h1_i} < H_LIM) &&
                    (fill_v0_i <= fill_v1_i) && ({1'b0, fill_v1_i} < V_LIM);
  assign accept   = (state_q == IDLE) && fill_start_i && start_ok;
  assign last_px  = (ch_q == h1_q) && (cv_q == v1_q);

  // A held CPU request is blocked while its ack is out, so it cannot issue twice.
  assign cpu_elig  = cpu_req_i && !ack_q;
  assign fill_elig = (state_q == RUN) && !abort;

  always_comb begin
    gnt_cpu  = cpu_elig;
    gnt_fill = fill_elig;
    rr_d     = rr_q;
    if (cpu_elig && fill_elig) begin
      gnt_cpu  = !rr_q;
      gnt_fill = rr_q;
      rr_d     = !rr_q;
    end
  end

  // Raster cursor: wrap to h0 on the right edge; v may step one past v1 on the last pixel.
  always_comb begin
    ch_d = ch_q;
    cv_d = cv_q;
    if (accept) begin
      ch_d = fill_h0_i;
      cv_d = fill_v0_i;
    end else if (gnt_fill) begin
      if (ch_q == h1_q) begin
        ch_d = h0_q;
        cv_d = cv_q + 1'b1;
      end else begin
        ch_d = ch_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_d = wr_q;
    if (gnt_cpu)       wr_d = '{h: cpu_h_i, v: cpu_v_i, d: cpu_data_i};
    else if (gnt_fill) wr_d = '{h: ch_q, v: cv_q, d: color_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q    <= 1'b0;
      wr_q    <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      h0_q    <= '0;
      h1_q    <= '0;
      v1_q    <= '0;
      color_q <= '0;
      ch_q    <= '0;
      cv_q    <= '0;
    end else begin
      rr_q  <= rr_d;
      wr_q  <= wr_d;
      we_q  <= gnt_cpu || gnt_fill;
      ack_q <= gnt_cpu;
      err_q <= (state_q == IDLE) && fill_start_i && !start_ok;
      ch_q  <= ch_d;
      cv_q  <= cv_d;
      if (accept) begin
        h0_q    <= fill_h0_i;
        h1_q    <= fill_h1_i;
        v1_q    <= fill_v1_i;
        color_q <= fill_color_i;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN: begin
        if (abort)                    state_d = IDLE;
        else if (gnt_fill && last_px) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fill_busy_o = (state_q == RUN);
    fill_done_o = (state_q == DONE);
    fill_err_o  = err_q;
    cpu_ack_o   = ack_q;
    we_o        = we_q;
    waddr_h_o   = wr_q.h;
    waddr_v_o   = wr_q.v;
    vga_wdata_o = wr_q.d;
  end
endmodule

// File: tb/tb_vmem_write_arbiter.sv
`timescale 1ns/1ps
// Directed bench for vmem_write_arbiter: drives and samples on the falling edge.
module tb_vmem_write_arbiter;
  localparam int H_W = 10, V_W = 9, DATA_W = 24;

  logic              clk = 1'b0, rst_n = 1'b0;
  logic              cpu_req_i = 1'b0, cpu_ack_o;
  logic [H_W-1:0]    cpu_h_i = '0;
  logic [V_W-1:0]    cpu_v_i = '0;
  logic [DATA_W-1:0] cpu_data_i = '0;
  logic              fill_start_i = 1'b0;
  logic [H_W-1:0]    fill_h0_i = '0, fill_h1_i = '0;
  logic [V_W-1:0]    fill_v0_i = '0, fill_v1_i = '0;
  logic [DATA_W-1:0] fill_color_i = '0;
  logic              fill_abort_i = 1'b0;
  logic              fill_busy_o, fill_done_o, fill_err_o, we_o;
  logic [H_W-1:0]    waddr_h_o;
  logic [V_W-1:0]    waddr_v_o;
  logic [DATA_W-1:0] vga_wdata_o;

  vmem_write_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req_i(cpu_req_i), .cpu_h_i(cpu_h_i), .cpu_v_i(cpu_v_i), .cpu_data_i(cpu_data_i),
    .cpu_ack_o(cpu_ack_o),
    .fill_start_i(fill_start_i), .fill_h0_i(fill_h0_i), .fill_v0_i(fill_v0_i),
    .fill_h1_i(fill_h1_i), .fill_v1_i(fill_v1_i), .fill_color_i(fill_color_i),
`ifdef VMEM_FILL_ABORT_EN
    .fill_abort_i(fill_abort_i),
`endif
    .fill_busy_o(fill_busy_o), .fill_done_o(fill_done_o), .fill_err_o(fill_err_o),
    .waddr_h_o(waddr_h_o), .waddr_v_o(waddr_v_o), .we_o(we_o), .vga_wdata_o(vga_wdata_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic start_fill(input int h0, input int v0, input int h1, input int v1, input int col);
    fill_h0_i    = H_W'(h0);
    fill_v0_i    = V_W'(v0);
    fill_h1_i    = H_W'(h1);
    fill_v1_i    = V_W'(v1);
    fill_color_i = DATA_W'(col);
    fill_start_i = 1'b1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_we"},   32'(we_o),        0);
    chk({tag, "_ack"},  32'(cpu_ack_o),   0);
    chk({tag, "_busy"}, 32'(fill_busy_o), 0);
    chk({tag, "_done"}, 32'(fill_done_o), 0);
    chk({tag, "_err"},  32'(fill_err_o),  0);
    chk({tag, "_h"},    32'(waddr_h_o),   0);
    chk({tag, "_v"},    32'(waddr_v_o),   0);
    chk({tag, "_d"},    32'(vga_wdata_o), 0);
  endtask

  task automatic err_case(input string tag, input int h0, input int v0, input int h1, input int v1);
    int nw, nb;
    start_fill(h0, v0, h1, v1, 32'h0000FF);
    @(negedge clk);
    fill_start_i = 1'b0;
    chk({tag, "_err"}, 32'(fill_err_o), 1);
    nw = int'(we_o);
    nb = int'(fill_busy_o);
    repeat (4) begin
      @(negedge clk);
      nw += int'(we_o);
      nb += int'(fill_busy_o);
    end
    chk({tag, "_err_end"}, 32'(fill_err_o), 0);
    chk({tag, "_nwr"}, 32'(nw), 0);
    chk({tag, "_busy"}, 32'(nb), 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nw, nb, nd, nack, nf, first_i, last_i, done_i;
    bit drop;
    logic [31:0] we_pat, ack_pat;
    int eh[6] = '{2, 3, 4, 2, 3, 4};
    int ev[6] = '{3, 3, 3, 4, 4, 4};

    // Reset and idle
    repeat (2) @(negedge clk);
    chk_zero("rst");
    rst_n = 1'b1;
    nw = 0;
    repeat (10) begin @(negedge clk); nw += int'(we_o); end
    chk("idle_nwr", 32'(nw), 0);

    // Single CPU write, request held through the ack cycle
    cpu_req_i = 1'b1; cpu_h_i = 10'd5; cpu_v_i = 9'd7; cpu_data_i = 24'hFF0000;
    nw = 0; first_i = -1; drop = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (we_o) begin
        nw++;
        if (first_i < 0) first_i = i;
        chk("cpu_h", 32'(waddr_h_o), 5);
        chk("cpu_v", 32'(waddr_v_o), 7);
        chk("cpu_d", 32'(vga_wdata_o), 32'hFF0000);
        chk("cpu_ack", 32'(cpu_ack_o), 1);
      end
      if (drop) cpu_req_i = 1'b0;
      if (cpu_ack_o) drop = 1'b1;
    end
    chk("cpu_nwr", 32'(nw), 1);
    chk("cpu_lat", 32'(first_i), 1);
    repeat (2) @(negedge clk);

    // Uncontended 3x2 fill
    start_fill(2, 3, 4, 4, 32'h00FF00);
    nw = 0; nb = 0; nd = 0; first_i = -1; last_i = -1; done_i = -1; nack = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      nb   += int'(fill_busy_o);
      nack += int'(cpu_ack_o);
      if (fill_done_o) begin nd++; done_i = i; end
      if (we_o) begin
        if (first_i < 0) first_i = i;
        last_i = i;
        if (nw < 6) begin
          chk("fill_h", 32'(waddr_h_o), 32'(eh[nw]));
          chk("fill_v", 32'(waddr_v_o), 32'(ev[nw]));
          chk("fill_d", 32'(vga_wdata_o), 32'h00FF00);
        end
        nw++;
      end
    end
    chk("fill_nwr", 32'(nw), 6);
    chk("fill_first", 32'(first_i), 2);
    chk("fill_consec", 32'(last_i - first_i), 5);
    chk("fill_ndone", 32'(nd), 1);
    chk("fill_done_last", 32'(done_i), 32'(last_i));
    chk("fill_busy", 32'(nb), 6);
    chk("fill_noack", 32'(nack), 0);

    // 10-pixel fill against continuous CPU traffic
    start_fill(0, 0, 9, 0, 32'hABCDEF);
    cpu_req_i = 1'b1; cpu_h_i = 10'd100; cpu_v_i = 9'd200; cpu_data_i = '0;
    we_pat = '0; ack_pat = '0; nack = 0; nf = 0; done_i = -1; drop = 1'b0;
    for (int i = 1; i <= 18; i++) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      we_pat[i]  = we_o;
      ack_pat[i] = cpu_ack_o;
      if (fill_done_o) done_i = i;
      if (drop) cpu_req_i = 1'b0;
      if (cpu_ack_o) begin
        chk("mix_cpu_h", 32'(waddr_h_o), 32'(100 + nack));
        chk("mix_cpu_v", 32'(waddr_v_o), 200);
        chk("mix_cpu_d", 32'(vga_wdata_o), 32'(nack));
        nack++;
        if (nack == 6) drop = 1'b1;
        else begin
          cpu_h_i    = H_W'(100 + nack);
          cpu_data_i = DATA_W'(nack);
        end
      end else if (we_o) begin
        chk("mix_fill_h", 32'(waddr_h_o), 32'(nf));
        chk("mix_fill_v", 32'(waddr_v_o), 0);
        chk("mix_fill_d", 32'(vga_wdata_o), 32'hABCDEF);
        nf++;
      end
    end
    chk("mix_we_pat", we_pat, 32'h0001_FFFE);
    chk("mix_ack_pat", ack_pat, 32'h0000_924A);
    chk("mix_nfill", 32'(nf), 10);
    chk("mix_ncpu", 32'(nack), 6);
    chk("mix_done", 32'(done_i), 16);
    repeat (2) @(negedge clk);

    // Rejected starts
    err_case("err_h1", 0, 0, 640, 0);
    err_case("err_hord", 6, 0, 5, 0);
    err_case("err_v1", 0, 0, 0, 480);

    // 1x1 fill at the far corner
    start_fill(639, 479, 639, 479, 32'h123456);
    nw = 0; nd = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      nd += int'(fill_done_o);
      if (we_o) begin
        nw++;
        chk("one_h", 32'(waddr_h_o), 639);
        chk("one_v", 32'(waddr_v_o), 479);
        chk("one_d", 32'(vga_wdata_o), 32'h123456);
        chk("one_done", 32'(fill_done_o), 1);
      end
    end
    chk("one_nwr", 32'(nw), 1);
    chk("one_ndone", 32'(nd), 1);

    // Reset in the middle of a 4x4 fill
    start_fill(10, 20, 13, 23, 32'h0F0F0F);
    nw = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      nw += int'(we_o);
      if (nw == 3) break;
    end
    chk("mid_seen", 32'(nw), 3);
    rst_n = 1'b0;
    #1;
    chk_zero("mid_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nw = 0; nd = 0; nb = 0;
    repeat (20) begin
      @(negedge clk);
      nw += int'(we_o);
      nd += int'(fill_done_o);
      nb += int'(fill_busy_o);
    end
    chk("post_rst_nwr", 32'(nw), 0);
    chk("post_rst_done", 32'(nd), 0);
    chk("post_rst_busy", 32'(nb), 0);

`ifdef VMEM_FILL_ABORT_EN
    // Abort after three pixels
    start_fill(10, 20, 13, 23, 32'h0F0F0F);
    nw = 0; nd = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      fill_start_i = 1'b0;
      nw += int'(we_o);
      if (nw == 3) break;
    end
    fill_abort_i = 1'b1;
    @(negedge clk);
    fill_abort_i = 1'b0;
    nw += int'(we_o);
    nd += int'(fill_done_o);
    chk("abort_busy", 32'(fill_busy_o), 0);
    nb = 0;
    repeat (10) begin
      @(negedge clk);
      nw += int'(we_o);
      nd += int'(fill_done_o);
      nb += int'(fill_busy_o);
    end
    chk("abort_nwr_le4", 32'(nw <= 4), 1);
    chk("abort_done", 32'(nd), 0);
    chk("abort_busy_after", 32'(nb), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
